// File: rtl/rom_dl_pkg.sv
// Shared types and helpers for the ROM download writer: write-entry layout,
// issue FSM states and the default tile-region base address.
package rom_dl_pkg;

  localparam logic [24:0] TILE_BASE_DEFAULT = 25'h20000;

  typedef struct packed {
    logic        port_sel;   // 0 = port1 (cpu/sound/sprite), 1 = port2 (tiles)
    logic [22:0] word_addr;
    logic [1:0]  ds;         // {hi, lo} byte enables
    logic [15:0] data;
  } wr_entry_t;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } issue_state_t;

  // Builds a write entry from a byte address, choosing the SDRAM port and
  // rebasing tile-region addresses so port2 starts at word 0.
  function automatic wr_entry_t make_entry(input logic [24:0] addr,
                                           input logic [24:0] tile_base,
                                           input logic [1:0]  ds,
                                           input logic [15:0] data);
    wr_entry_t   e;
    logic [24:0] off;
    if (addr < tile_base) begin
      e.port_sel = 1'b0;
      off        = addr;
    end else begin
      e.port_sel = 1'b1;
      off        = addr - tile_base;
    end
    e.word_addr = off[23:1];
    e.ds        = ds;
    e.data      = data;
    return e;
  endfunction

endpackage

// File: rtl/rom_download_writer_if.sv
// SDRAM write-port bundle: two toggle req/ack pairs sharing one address,
// byte-enable, data and write-enable bus.
interface rom_download_writer_if;
  logic        port1_req;
  logic        port1_ack;
  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we;

  modport master (
    output port1_req, port2_req, port_a, port_ds, port_d, port_we,
    input  port1_ack, port2_ack
  );

  modport slave (
    input  port1_req, port2_req, port_a, port_ds, port_d, port_we,
    output port1_ack, port2_ack
  );
endinterface

// File: rtl/rom_dl_fifo.sv
// Small synchronous FIFO of write entries with show-ahead output.
// A push while full is refused; the caller decides what that means.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wr_entry_t              din,
  input  logic                   pop,
  output wr_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wr_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = push & ~full;
  assign do_rd = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking, allowing push and pop in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_download_writer.sv
// Turns the ioctl download byte stream into 16-bit SDRAM writes: pairs bytes,
// queues words, issues them over toggle req/ack, and raises rom_loaded only
// once every queued write has been acknowledged (or abandoned on timeout).
module rom_download_writer
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] TILE_BASE   = TILE_BASE_DEFAULT,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_downl,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic                  user_reset,
  rom_download_writer_if.master sdram,
  output logic                  rom_loaded,
  output logic                  core_reset,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic                         wr_d;
  logic                         downl_d;
  logic                         byte_take;
  logic                         downl_rise;
  logic                         downl_fall;

  logic [24:0]                  hold_addr;
  logic [7:0]                   hold_data;
  logic                         hold_valid;
  logic                         hold_load;
  logic                         hold_clear;

  logic                         push;
  wr_entry_t                    push_entry;
  wr_entry_t                    fifo_dout;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         pop;

  issue_state_t                 state;
  issue_state_t                 state_next;
  logic                         cur_sel;
  logic [CNT_W-1:0]             cnt;
  logic                         ack_fix1;
  logic                         ack_fix2;
  logic                         sel_req;
  logic                         sel_ack;
  logic                         timed_out;
  logic                         end_seen;

  assign byte_take  = ioctl_wr & ~wr_d & ioctl_downl;
  assign downl_rise = ioctl_downl & ~downl_d;
  assign downl_fall = ~ioctl_downl & downl_d;

  // Edge-detect registers for the byte strobe and the download flag.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_d    <= 1'b0;
      downl_d <= 1'b0;
    end else begin
      wr_d    <= ioctl_wr;
      downl_d <= ioctl_downl;
    end
  end

  // Pairing decision: merge an even/odd byte pair, otherwise flush the held
  // byte as a single-lane write with the byte duplicated in both halves.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (byte_take) begin
      if (hold_valid && !hold_addr[0] && (ioctl_addr == hold_addr + 25'd1)) begin
        push       = 1'b1;
        push_entry = make_entry(hold_addr, TILE_BASE, 2'b11, {ioctl_dout, hold_data});
        hold_clear = 1'b1;
      end else begin
        if (hold_valid) begin
          push       = 1'b1;
          push_entry = make_entry(hold_addr, TILE_BASE,
                                  hold_addr[0] ? 2'b10 : 2'b01, {hold_data, hold_data});
        end
        hold_load = 1'b1;
      end
    end else if (downl_fall && hold_valid) begin
      push       = 1'b1;
      push_entry = make_entry(hold_addr, TILE_BASE,
                              hold_addr[0] ? 2'b10 : 2'b01, {hold_data, hold_data});
      hold_clear = 1'b1;
    end
  end

  // Hold register for the byte still waiting for its partner.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (hold_load) begin
      hold_addr  <= ioctl_addr;
      hold_data  <= ioctl_dout;
      hold_valid <= 1'b1;
    end else if (hold_clear) begin
      hold_valid <= 1'b0;
    end
  end

  rom_dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_entry),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The ack-fix bits offset a port's ack after a timeout so a lost ack
  // does not leave that port permanently out of step.
  assign sel_req = cur_sel ? sdram.port2_req : sdram.port1_req;
  assign sel_ack = cur_sel ? (sdram.port2_ack ^ ack_fix2) : (sdram.port1_ack ^ ack_fix1);

  // Issue FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Issue FSM next state: pop when idle, wait for matching ack or timeout.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sel_ack == sel_req) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write datapath: latch the bus and toggle the request on issue, count
  // while waiting, and resync the ack tracking on timeout.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sdram.port1_req <= 1'b0;
      sdram.port2_req <= 1'b0;
      sdram.port_a    <= '0;
      sdram.port_ds   <= '0;
      sdram.port_d    <= '0;
      cur_sel         <= 1'b0;
      cnt             <= '0;
      ack_fix1        <= 1'b0;
      ack_fix2        <= 1'b0;
    end else begin
      if (pop) begin
        sdram.port_a  <= fifo_dout.word_addr;
        sdram.port_ds <= fifo_dout.ds;
        sdram.port_d  <= fifo_dout.data;
        cur_sel       <= fifo_dout.port_sel;
        cnt           <= '0;
        if (fifo_dout.port_sel) sdram.port2_req <= ~sdram.port2_req;
        else                    sdram.port1_req <= ~sdram.port1_req;
      end else if (state == WAIT_ACK) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (timed_out) begin
        if (cur_sel) ack_fix2 <= ~ack_fix2;
        else         ack_fix1 <= ~ack_fix1;
      end
    end
  end

  assign sdram.port_we = ioctl_downl | (state != IDLE) | (fifo_count != '0) | hold_valid;

  // Completion, sticky error flags and the registered core reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      end_seen    <= 1'b0;
      rom_loaded  <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      core_reset  <= 1'b1;
    end else begin
      if (downl_rise) begin
        end_seen    <= 1'b0;
        rom_loaded  <= 1'b0;
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        if (downl_fall) end_seen <= 1'b1;
        if (end_seen && fifo_empty && !hold_valid && (state == IDLE)) rom_loaded <= 1'b1;
      end
      if (push && fifo_full) overflow    <= 1'b1;
      if (timed_out)         timeout_err <= 1'b1;
      core_reset <= user_reset | ~rom_loaded;
    end
  end

endmodule

// File: tb/tb_rom_download_writer.sv
// Scoreboard bench for rom_download_writer: stimulus pushes hand-computed
// writes into a queue, a monitor pops and compares on every req toggle.
module tb_rom_download_writer;
  import rom_dl_pkg::*;

  logic        clk_sys     = 1'b0;
  logic        reset_n     = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr    = 1'b0;
  logic [24:0] ioctl_addr  = '0;
  logic [7:0]  ioctl_dout  = '0;
  logic        user_reset  = 1'b0;
  logic        rom_loaded;
  logic        core_reset;
  logic        overflow;
  logic        timeout_err;

  rom_download_writer_if sdram ();

  rom_download_writer dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .user_reset  (user_reset),
    .sdram       (sdram),
    .rom_loaded  (rom_loaded),
    .core_reset  (core_reset),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #10 clk_sys = ~clk_sys;

  int        n_cmp = 0;
  int        n_bad = 0;
  wr_entry_t exp_q[$];

  logic      ack_enable = 1'b1;
  int        ack_delay  = 2;
  logic      pend1 = 1'b0, pend2 = 1'b0;
  int        cnt1 = 0, cnt2 = 0;
  logic      mreq1 = 1'b0, mreq2 = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic sel, input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    wr_entry_t e;
    e.port_sel  = sel;
    e.word_addr = a;
    e.ds        = ds;
    e.data      = d;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [24:0] addr, input logic [7:0] data, input int gap);
    @(posedge clk_sys); #1;
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b0;
    repeat (gap) @(posedge clk_sys);
  endtask

  task automatic start_dl();
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    ioctl_downl = 1'b0;
  endtask

  task automatic wait_loaded(input string name);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk_sys); #1;
      if (rom_loaded) break;
    end
    check_output(name, rom_loaded, 1);
  endtask

  // SDRAM ack model: one ack toggle per observed req toggle after ack_delay
  // cycles; with ack_enable low the request is silently lost.
  initial begin
    sdram.port1_ack = 1'b0;
    sdram.port2_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        sdram.port1_ack = 1'b0; sdram.port2_ack = 1'b0;
        pend1 = 1'b0; pend2 = 1'b0; mreq1 = 1'b0; mreq2 = 1'b0;
      end else begin
        if (sdram.port1_req !== mreq1) begin
          mreq1 = sdram.port1_req;
          if (ack_enable) begin pend1 = 1'b1; cnt1 = ack_delay; end
        end
        if (pend1) begin
          if (cnt1 == 0) begin sdram.port1_ack = ~sdram.port1_ack; pend1 = 1'b0; end
          else cnt1--;
        end
        if (sdram.port2_req !== mreq2) begin
          mreq2 = sdram.port2_req;
          if (ack_enable) begin pend2 = 1'b1; cnt2 = ack_delay; end
        end
        if (pend2) begin
          if (cnt2 == 0) begin sdram.port2_ack = ~sdram.port2_ack; pend2 = 1'b0; end
          else cnt2--;
        end
      end
    end
  end

  // Monitor: every req toggle is a write to score; while an ack is pending
  // the bus must hold the value presented at issue.
  initial begin
    logic        p1 = 1'b0, p2 = 1'b0;
    wr_entry_t   got;
    wr_entry_t   e;
    logic [40:0] cap = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        p1 = 1'b0; p2 = 1'b0;
      end else if (sdram.port1_req !== p1 || sdram.port2_req !== p2) begin
        got.port_sel  = (sdram.port2_req !== p2);
        got.word_addr = sdram.port_a;
        got.ds        = sdram.port_ds;
        got.data      = sdram.port_d;
        cap = {sdram.port_a, sdram.port_ds, sdram.port_d};
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL unexpected write: got %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check_output("write", 64'(got), 64'(e));
        end
        p1 = sdram.port1_req;
        p2 = sdram.port2_req;
      end else if (pend1 || pend2) begin
        check_output("bus stable", 64'({sdram.port_a, sdram.port_ds, sdram.port_d}), 64'(cap));
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int i;
    // Reset values
    repeat (3) @(posedge clk_sys); #1;
    check_output("reset req1", sdram.port1_req, 0);
    check_output("reset req2", sdram.port2_req, 0);
    check_output("reset bus", {sdram.port_a, sdram.port_ds, sdram.port_d}, 0);
    check_output("reset rom_loaded", rom_loaded, 0);
    check_output("reset core_reset", core_reset, 1);
    check_output("reset flags", {overflow, timeout_err}, 0);
    check_output("reset port_we", sdram.port_we, 0);
    reset_n = 1'b1;

    // Paired bytes A5@0, 5A@1
    expect_write(1'b0, 23'd0, 2'b11, 16'h5AA5);
    start_dl();
    apply_stimulus(25'h0, 8'hA5, 2);
    apply_stimulus(25'h1, 8'h5A, 2);
    check_output("loaded during dl", rom_loaded, 0);
    end_dl();
    wait_loaded("loaded pair");
    repeat (2) @(posedge clk_sys); #1;
    check_output("core_reset released", core_reset, 0);
    user_reset = 1'b1;
    repeat (2) @(posedge clk_sys); #1;
    check_output("user_reset", core_reset, 1);
    user_reset = 1'b0;

    // Lone byte in tile region
    expect_write(1'b1, 23'd1, 2'b10, 16'h3333);
    start_dl();
    check_output("loaded cleared", rom_loaded, 0);
    check_output("core_reset on new dl", core_reset, 1);
    apply_stimulus(25'h20003, 8'h33, 2);
    end_dl();
    wait_loaded("loaded tile");

    // Non-consecutive bytes
    expect_write(1'b0, 23'd0, 2'b01, 16'h1111);
    expect_write(1'b0, 23'd2, 2'b01, 16'h2222);
    start_dl();
    apply_stimulus(25'h0, 8'h11, 2);
    apply_stimulus(25'h4, 8'h22, 2);
    end_dl();
    wait_loaded("loaded split");

    // Burst with slow acks
    ack_delay = 10;
    expect_write(1'b0, 23'h80, 2'b11, 16'h1110);
    expect_write(1'b0, 23'h81, 2'b11, 16'h1312);
    expect_write(1'b0, 23'h82, 2'b11, 16'h1514);
    expect_write(1'b0, 23'h83, 2'b11, 16'h1716);
    expect_write(1'b0, 23'h84, 2'b11, 16'h1918);
    expect_write(1'b0, 23'h85, 2'b11, 16'h1B1A);
    start_dl();
    for (int k = 0; k < 12; k++) apply_stimulus(25'h100 + 25'(k), 8'h10 + 8'(k), 1);
    end_dl();
    #2;
    check_output("port_we while draining", sdram.port_we, 1);
    wait_loaded("loaded burst");
    check_output("burst overflow", overflow, 0);
    ack_delay = 2;

    // Lost ack
    expect_write(1'b0, 23'h8, 2'b01, 16'h4444);
    expect_write(1'b0, 23'h10, 2'b10, 16'h6666);
    ack_enable = 1'b0;
    start_dl();
    apply_stimulus(25'h10, 8'h44, 2);
    apply_stimulus(25'h21, 8'h66, 2);
    end_dl();
    for (i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (timeout_err) break;
    end
    ack_enable = 1'b1;
    check_output("timeout_err set", timeout_err, 1);
    check_output("timeout latency", (i >= 200 && i <= 300), 1);
    wait_loaded("loaded after timeout");
    check_output("timeout sticky", timeout_err, 1);

    // Reset mid-wait
    ack_delay = 50;
    expect_write(1'b0, 23'd0, 2'b11, 16'h5AA5);
    start_dl();
    check_output("timeout cleared", timeout_err, 0);
    apply_stimulus(25'h0, 8'hA5, 2);
    apply_stimulus(25'h1, 8'h5A, 5);
    @(posedge clk_sys); #1;
    reset_n     = 1'b0;
    ioctl_downl = 1'b0;
    repeat (3) @(posedge clk_sys); #1;
    check_output("midreset req1", sdram.port1_req, 0);
    check_output("midreset rom_loaded", rom_loaded, 0);
    check_output("midreset core_reset", core_reset, 1);
    reset_n   = 1'b1;
    ack_delay = 2;
    expect_write(1'b0, 23'd1, 2'b11, 16'h8877);
    start_dl();
    apply_stimulus(25'h2, 8'h77, 2);
    apply_stimulus(25'h3, 8'h88, 6);
    check_output("core_reset before end", core_reset, 1);
    check_output("loaded before end", rom_loaded, 0);
    end_dl();
    wait_loaded("loaded after reset");
    repeat (2) @(posedge clk_sys); #1;
    check_output("core_reset final", core_reset, 0);
    check_output("pending writes", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_download_writer.md
Name: rom_download_writer

Overview:
- Sits between the ROM-download SPI front end (ioctl byte stream) and the two SDRAM write ports: port1 carries CPU/sound/sprite ROM, port2 carries background tile ROM.
- Pairs consecutive bytes into 16-bit words and buffers them in a small FIFO.
- Issues each buffered write over a toggle req/ack handshake to the SDRAM port selected by address.
- Generates rom_loaded and the core reset only after every write has been acknowledged.

Parameters:
- TILE_BASE, 25'h20000, byte address where the tile region starts; addresses at or above it go to port2, rebased by subtracting TILE_BASE.
- FIFO_DEPTH, 4, write-word FIFO entries (power of 2, ≥2).
- ACK_TIMEOUT, 255, clk_sys cycles to wait for an ack before abandoning the write.

Ports:
- clk_sys  in  1  system clock (48 MHz).
- reset_n  in  1  synchronous, active-low reset.
- ioctl_downl  in  1  download in progress.
- ioctl_wr  in  1  byte strobe; a rising edge means one byte.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- user_reset  in  1  OSD reset request.
- port1_req / port2_req  out  1  toggle request.
- port1_ack / port2_ack  in  1  toggle acknowledge.
- port_a  out  23  word address (shared by both ports).
- port_ds  out  2  byte enables {hi, lo}.
- port_d  out  16  write data.
- port_we  out  1  write enable; high while ioctl_downl is high or the block is busy.
- rom_loaded  out  1  all bytes committed.
- core_reset  out  1  active-high reset to the core.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- timeout_err  out  1  sticky: an ack timed out.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - Outputs: reqs=0, port_a/ds/d=0, rom_loaded=0, core_reset=1, overflow=0, timeout_err=0.
  - Internal state: FIFO empty, hold register invalid, FSM IDLE.
  - A reset in the middle of a write abandons it; req is not re-toggled.
- Byte capture:
  - ioctl_wr is registered; a byte is taken on (ioctl_wr & ~ioctl_wr_d) while ioctl_downl=1.
  - Strobes seen while ioctl_downl=0 are ignored.
- Pairing, with a hold register {addr, data, valid}:
  - Hold valid, hold addr even, new addr = hold addr+1: push word {new,hold}, ds=2'b11, clear hold.
  - Otherwise: if hold is valid, push it (ds=2'b01 for an even address, 2'b10 for odd, data duplicated in both halves); then load the new byte into hold.
  - At most one push per cycle.
  - On the falling edge of ioctl_downl: if hold is valid, push it and clear hold.
- FIFO:
  - Entry holds {port_sel, word_addr[22:0], ds, data}.
  - Write and read in the same cycle are allowed.
  - A push while full drops the entry and sets overflow.
- Port select:
  - byte addr < TILE_BASE: port1, word_addr = addr[23:1].
  - Otherwise: port2, word_addr = (addr - TILE_BASE)[23:1].
- Issue FSM (IDLE, WAIT_ACK):
  - IDLE & FIFO non-empty: pop, register port_a/ds/d, toggle the selected req in the same cycle, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: when the selected ack equals its req, go to IDLE; the next pop can happen on the following cycle.
  - When the counter reaches ACK_TIMEOUT: set timeout_err, force that port's internal ack-tracking equal to req, go to IDLE.
  - port_a/ds/d stay stable from the issue cycle until the FSM leaves WAIT_ACK.
- Completion:
  - Falling edge of ioctl_downl sets end_seen.
  - rom_loaded <= 1 when end_seen & FIFO empty & hold invalid & FSM=IDLE.
  - Rising edge of ioctl_downl clears rom_loaded, end_seen, overflow and timeout_err.
- core_reset is registered: user_reset | ~rom_loaded.

Decomposition:
- Shared package rom_dl_pkg holds:
  - typedef wr_entry_t {port_sel, word_addr[22:0], ds[1:0], data[15:0]};
  - enum issue_state_t {IDLE, WAIT_ACK};
  - constant TILE_BASE_DEFAULT.
- One sub-module: rom_dl_fifo, a synchronous FIFO of wr_entry_t with full, empty and count outputs.

Test Plan:
- Reset, then download bytes A5@0 and 5A@1: exactly one port1 toggle with port_a=0, ds=11, d=16'h5AA5; rom_loaded rises after the ack and after ioctl_downl falls.
- Lone byte 33@0x20003 then download end: port2 write with port_a=1, ds=10, d=16'h3333.
- Bytes at 0x0 then 0x4 (non-consecutive): two writes, ds=01 at word 0 and ds=01 at word 2.
- Hold acks for 10 cycles with FIFO_DEPTH=4 and burst 12 bytes: no overflow; FIFO stalls and drains; port_a/d stay stable during each wait.
- Never ack: timeout_err=1 after 255 cycles; the next entry still issues; rom_loaded still asserts at the end.
- Drop reset_n mid-WAIT_ACK, then start a new download: rom_loaded=0 and core_reset=1 until the new download completes.
